// File: rtl/press_classifier_if.sv
// press_classifier_if: button level in, gesture ticks and busy out.
//   level       debounced button level, 1 = pressed
//   short_tick  single short press committed
//   long_tick   first press held long enough
//   double_tick second press started inside the gap window
//   repeat_tick auto-repeat pulse while a long press is held
//   busy        a gesture is in progress
interface press_classifier_if;
  logic level;
  logic short_tick;
  logic long_tick;
  logic double_tick;
  logic repeat_tick;
  logic busy;
  modport master (output level, input short_tick, long_tick, double_tick, repeat_tick, busy);
  modport slave (input level, output short_tick, long_tick, double_tick, repeat_tick, busy);
endinterface

// File: rtl/press_classifier.sv
// press_classifier: sorts debounced presses into short/long/double gestures with one-cycle ticks.
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    press_classifier_if.slave (level in; ticks and busy out, all registered)
// Optional macro PRESS_CLASSIFIER_HOLD_REPEAT_EN enables repeat_tick while a long press is held;
// without it repeat_tick is tied low and no repeat counting is built.
module press_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic clk,
  input logic reset,
  press_classifier_if.slave bus
);
  localparam int MAXP = (LONG_CYCLES > GAP_CYCLES) ?
    ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) :
    ((GAP_CYCLES > REPEAT_CYCLES) ? GAP_CYCLES : REPEAT_CYCLES);
  localparam int W = $clog2(MAXP) + 1;
  localparam logic [W-1:0] L_END = W'(LONG_CYCLES - 1);
  localparam logic [W-1:0] G_END = W'(GAP_CYCLES - 1);
`ifdef PRESS_CLASSIFIER_HOLD_REPEAT_EN
  localparam logic [W-1:0] R_END = W'(REPEAT_CYCLES - 1);
`endif
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic short_n, long_n, double_n, repeat_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.short_tick  <= 1'b0;
      bus.long_tick   <= 1'b0;
      bus.double_tick <= 1'b0;
      bus.repeat_tick <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      bus.short_tick  <= short_n;
      bus.long_tick   <= long_n;
      bus.double_tick <= double_n;
      bus.repeat_tick <= repeat_n;
      bus.busy        <= state_n != IDLE;
    end
  end
  // level=0 wins in PRESS1 and level=1 wins in WAIT_GAP, which settles both boundary samples
  always_comb begin
    state_n = state;
    case (state)
      IDLE:              state_n = bus.level ? PRESS1 : IDLE;
      PRESS1:            state_n = !bus.level ? WAIT_GAP : (cnt == L_END ? LONG_HELD : PRESS1);
      WAIT_GAP:          state_n = bus.level ? PRESS2 : (cnt == G_END ? IDLE : WAIT_GAP);
      PRESS2, LONG_HELD: state_n = bus.level ? state : IDLE;
      default:           state_n = IDLE;
    endcase
  end
  // counters only advance below their terminal value, so cnt can never wrap
  always_comb begin
    short_n  = state == WAIT_GAP && !bus.level && cnt == G_END;
    long_n   = state == PRESS1 && bus.level && cnt == L_END;
    double_n = state == WAIT_GAP && bus.level;
`ifdef PRESS_CLASSIFIER_HOLD_REPEAT_EN
    repeat_n = state == LONG_HELD && bus.level && cnt == R_END;
`else
    repeat_n = 1'b0;
`endif
    cnt_n = '0;
    case (state)
      IDLE:     cnt_n = bus.level ? W'(1) : '0;
      PRESS1:   cnt_n = !bus.level ? W'(1) : (long_n ? '0 : cnt + W'(1));
      WAIT_GAP: cnt_n = (bus.level || short_n) ? '0 : cnt + W'(1);
`ifdef PRESS_CLASSIFIER_HOLD_REPEAT_EN
      LONG_HELD: cnt_n = (bus.level && !repeat_n) ? cnt + W'(1) : '0;
`endif
      default:  cnt_n = '0;
    endcase
  end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed checks of press_classifier with LONG=8, GAP=4, REPEAT=3.
module tb_press_classifier;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  press_classifier_if bus ();
  press_classifier #(.LONG_CYCLES(8), .GAP_CYCLES(4), .REPEAT_CYCLES(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // expected vectors are {short, long, double, repeat, busy}
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.short_tick, bus.long_tick, bus.double_tick, bus.repeat_tick, bus.busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, obs, exp);
    end
  endtask
  // drive level for n cycles; outputs checked 1 ns after each edge
  task automatic hold(input string tag, input logic l, input int n, input logic [4:0] mid, input logic [4:0] last);
    for (int i = 1; i <= n; i++) begin
      bus.level = l;
      @(posedge clk);
      #1;
      check(tag, i == n ? last : mid);
    end
  endtask
  task automatic do_reset(input string tag, input logic l, input int n);
    reset = 1'b0;
    hold(tag, l, n, 5'b00000, 5'b00000);
    reset = 1'b1;
  endtask
  initial begin
    bus.level = 1'b0;
    // 1: reset with level held high, then release
    do_reset("reset_hold", 1'b1, 3);
    hold("reset_release", 1'b1, 1, 5'b00001, 5'b00001);
    do_reset("reset_clean", 1'b0, 1);
    // 2: short press
    hold("short_press", 1'b1, 3, 5'b00001, 5'b00001);
    hold("short_gap", 1'b0, 4, 5'b00001, 5'b10000);
    hold("short_after", 1'b0, 2, 5'b00000, 5'b00000);
    // 3: long press, 20 high samples
    hold("long_pre", 1'b1, 7, 5'b00001, 5'b00001);
    hold("long_tick", 1'b1, 1, 5'b00001, 5'b01001);
`ifdef PRESS_CLASSIFIER_HOLD_REPEAT_EN
    for (int k = 0; k < 4; k++) hold("repeat", 1'b1, 3, 5'b00001, 5'b00011);
`else
    hold("no_repeat", 1'b1, 12, 5'b00001, 5'b00001);
`endif
    hold("long_release", 1'b0, 3, 5'b00000, 5'b00000);
    // 4: double press
    hold("dbl_first", 1'b1, 2, 5'b00001, 5'b00001);
    hold("dbl_gap", 1'b0, 3, 5'b00001, 5'b00001);
    hold("dbl_tick", 1'b1, 1, 5'b00001, 5'b00101);
    hold("dbl_hold", 1'b1, 9, 5'b00001, 5'b00001);
    hold("dbl_release", 1'b0, 2, 5'b00000, 5'b00000);
    // 5: full gap then press -> short, then a fresh gesture
    hold("gap_first", 1'b1, 2, 5'b00001, 5'b00001);
    hold("gap_low", 1'b0, 4, 5'b00001, 5'b10000);
    hold("gap_fresh", 1'b1, 1, 5'b00001, 5'b00001);
    do_reset("gap_reset", 1'b0, 1);
    // release on the sample that would reach LONG counts as short
    hold("edge_press", 1'b1, 7, 5'b00001, 5'b00001);
    hold("edge_release", 1'b0, 4, 5'b00001, 5'b10000);
    hold("edge_idle", 1'b0, 1, 5'b00000, 5'b00000);
    // 6: reset mid-gesture, then 8 fresh samples for long
    hold("mid_press", 1'b1, 5, 5'b00001, 5'b00001);
    do_reset("mid_reset", 1'b1, 1);
    hold("mid_fresh", 1'b1, 7, 5'b00001, 5'b00001);
    hold("mid_long", 1'b1, 1, 5'b00001, 5'b01001);
    hold("mid_release", 1'b0, 2, 5'b00000, 5'b00000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Gesture classifier for the debounced button level from the debounce stage (its db_level output).
- Sorts each press into one of three gestures: short press, long press, or double press.
- Emits one single-cycle tick per gesture.
- Ticks drive counter enables, mode toggles or menu logic in the board top level, alongside the seven-segment mux.

Parameters:
- LONG_CYCLES, 50_000_000, consecutive high samples that make a long press (500 ms at 100 MHz); must be >= 2.
- GAP_CYCLES, 25_000_000, low samples after a first release before a short press is committed (250 ms); must be >= 2.
- REPEAT_CYCLES, 10_000_000, auto-repeat period while held; used only with HOLD_REPEAT_EN.

Ports:
- clk  input  1  system clock (100 MHz on board).
- reset  input  1  synchronous, active-low reset; 0 sampled at a rising clk edge resets the block.
- level  input  1  debounced button level, synchronous to clk, 1 = pressed.
- short_tick  output  1  one-cycle pulse: single short press committed.
- long_tick  output  1  one-cycle pulse: first press held LONG_CYCLES samples.
- double_tick  output  1  one-cycle pulse: second press started within the gap window.
- repeat_tick  output  1  one-cycle auto-repeat pulse; constant 0 without HOLD_REPEAT_EN.
- busy  output  1  high whenever state != IDLE.

Behaviour:
Reset and general rules:
- While reset=0 at an edge: state=IDLE, cnt=0, all outputs 0.
- Reset mid-gesture abandons the gesture with no tick.
- All outputs are registered.
- Ticks are mutually exclusive and last exactly one cycle.
- cnt is an internal counter, width $clog2 of the largest parameter + 1. It saturates and never wraps.

State machine (level sampled at each rising edge):
- IDLE: level=1 -> PRESS1, cnt=1 (the entry sample counts as sample 1).
- PRESS1, level=1: if cnt==LONG_CYCLES-1, assert long_tick at this edge and go to LONG_HELD with cnt=0. Otherwise cnt++.
- PRESS1, level=0: go to WAIT_GAP, cnt=1.
- WAIT_GAP, level=0: if cnt==GAP_CYCLES-1, assert short_tick and go to IDLE. Otherwise cnt++.
- WAIT_GAP, level=1: assert double_tick and go to PRESS2. The second press is not required to release first.
- PRESS2: level=0 -> IDLE. Holding does not produce long_tick; the gesture is already classified.
- LONG_HELD: level=0 -> IDLE.

Timing:
- long_tick is high in the cycle after the edge of sample LONG_CYCLES.
- short_tick is high in the cycle after the GAP_CYCLES-th low sample following release.

Boundaries:
- A 1-sample press followed by a long gap -> short_tick.
- A release on the exact sample where cnt would reach LONG_CYCLES counts as short, because level=0 takes priority in PRESS1.
- level=1 on the final gap sample -> double_tick, not short_tick, because level=1 is checked first in WAIT_GAP.
- A third press after PRESS2 releases starts a fresh gesture from IDLE.

Optional Feature:
Macro: PRESS_CLASSIFIER_HOLD_REPEAT_EN
- Defined:
  - In LONG_HELD with level=1, cnt counts up and repeat_tick pulses each time cnt reaches REPEAT_CYCLES-1; cnt then returns to 0.
  - First repeat_tick occurs REPEAT_CYCLES cycles after long_tick.
  - Release stops repeats immediately.
  - Repeats run only in LONG_HELD, never in PRESS2.
- Undefined: repeat_tick tied to 0 and no repeat counter logic is synthesized.

Test Plan:
All tests use LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3.
1. Reset held 0 for 3 cycles with level=1 -> all outputs 0 and busy=0. Release reset with level=1 -> busy=1 one cycle later.
2. Short press: level=1 for 3 cycles, then 0 -> exactly one short_tick, high in the cycle after the 4th low sample; no other ticks; busy drops with it.
3. Long press:
   - level=1 for 20 cycles -> one long_tick, in the cycle after the 8th high sample.
   - With macro: repeat_tick at 3 and 6 cycles after long_tick, 4 pulses total before release.
   - Without macro: repeat_tick stays 0.
4. Double press: level=1 for 2, 0 for 3, 1 for 10, then 0 -> one double_tick, in the cycle after the second rising sample; no short_tick or long_tick; busy=0 after the release.
5. Gap boundary: level=1 for 2, 0 for exactly 4, then 1 -> short_tick after the 4th low sample; the following press starts a new gesture (busy=1, no double_tick).
6. Reset mid-gesture: level=1 for 5 cycles, reset=0 for 1 cycle while level stays 1, then 3 more high cycles -> no long_tick; the block re-enters PRESS1 and long_tick occurs only after 8 fresh high samples.
